imem_loader: RTL and testbench

- Writer side of the instruction memory: receives a program as a byte stream and writes it word-by-word into instruction memory.
- The fetch stage only reads instruction memory; this block fills it before execution begins.
- Holds the pipeline through cpu_hold until the load completes. Fetch gates its enable with cpu_hold.
- Stream format: 32-bit big-endian word count N, then N big-endian instruction words.

---
 rtl/imem_loader_if.sv | 28 ++
 rtl/imem_loader.sv | 112 +++++++++++
 tb/tb_imem_loader.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write bus of the program loader.
// The master side is the stream source and memory model. The slave side is the loader.
interface imem_loader_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output mem_we,
    output mem_addr,
    output mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory loader. It receives a big-endian word count N, then N
// big-endian instruction words. Each word is written to consecutive word
// addresses starting at BASE_ADDR. The CPU is held until the load completes.
module imem_loader #(
  parameter int          ADDR_WIDTH = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          MAX_WORDS  = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  imem_loader_if.slave          bus,
  output logic                  cpu_hold,
  output logic                  load_done,
  output logic                  load_error,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] HDR  = 3'd1;
  localparam logic [2:0] DATA = 3'd2;
  localparam logic [2:0] DONE = 3'd3;
  localparam logic [2:0] ERR  = 3'd4;

  logic [2:0]          state;
  logic [1:0]          byte_cnt;   // bytes already held for the current 32-bit value
  logic [23:0]         shift;      // first three bytes of the value being assembled
  logic [ADDR_WIDTH:0] n_words;    // word count taken from the header
  logic [31:0]         ptr;        // byte address of the next word to write

  logic                accept;
  logic                last_byte;
  logic [31:0]         full_word;
  logic [ADDR_WIDTH:0] wl_inc;

  // Status outputs follow directly from the state.
  assign bus.in_ready = (state == HDR) || (state == DATA);
  assign cpu_hold     = (state != DONE);
  assign load_done    = (state == DONE);
  assign load_error   = (state == ERR);

  // A byte transfers on valid && ready. The fourth byte completes a 32-bit value.
  assign accept    = bus.in_valid && bus.in_ready;
  assign last_byte = (byte_cnt == 2'd3);
  assign full_word = {shift, bus.in_data};
  assign wl_inc    = words_loaded + 1'b1;

  // Run the load sequencer, assemble bytes, and issue one write per word.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: registers use non-blocking assignments so that every
      // right-hand side in this block reads the pre-edge value.
      state         <= IDLE;
      byte_cnt      <= 2'd0;
      shift         <= 24'd0;
      n_words       <= '0;
      ptr           <= BASE_ADDR;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= BASE_ADDR;
      bus.mem_wdata <= 32'd0;
      words_loaded  <= '0;
    end else begin
      // The write strobe is a single-cycle pulse. Address and data hold their values.
      bus.mem_we <= 1'b0;
      case (state)
        IDLE: begin
          if (start) state <= HDR;
        end
        HDR: begin
          if (accept) begin
            byte_cnt <= byte_cnt + 2'd1;
            shift    <= {shift[15:0], bus.in_data};
            if (last_byte) begin
              words_loaded <= '0;
              ptr          <= BASE_ADDR;
              if (full_word == 32'd0) begin
                state <= DONE;
              end else if (full_word > 32'(MAX_WORDS)) begin
                state <= ERR;
              end else begin
                n_words <= full_word[ADDR_WIDTH:0];
                state   <= DATA;
              end
            end
          end
        end
        DATA: begin
          if (accept) begin
            byte_cnt <= byte_cnt + 2'd1;
            shift    <= {shift[15:0], bus.in_data};
            if (last_byte) begin
              bus.mem_we    <= 1'b1;
              bus.mem_addr  <= ptr;
              bus.mem_wdata <= full_word;
              ptr           <= ptr + 32'd4;
              words_loaded  <= wl_inc;
              if (wl_inc == n_words) state <= DONE;
            end
          end
        end
        DONE: begin
          if (start) state <= HDR;
        end
        ERR: begin
          state <= ERR;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader. Table-driven random loads run against a
// scoreboard of expected writes. Hand-written sequences cover the corner cases.
module tb_imem_loader;

  localparam int          ADDR_WIDTH = 10;
  localparam logic [31:0] BASE_ADDR  = 32'h0000_0000;
  localparam int          MAX_WORDS  = 1024;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic [31:0] n;        // header word count
    int          gap_pct;  // chance of an idle cycle before each byte
    logic [31:0] exp_wl;   // expected words_loaded once finished
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic cpu_hold, load_done, load_error;
  logic [ADDR_WIDTH:0] words_loaded;

  imem_loader_if bus();

  imem_loader #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .BASE_ADDR (BASE_ADDR),
    .MAX_WORDS (MAX_WORDS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .bus         (bus),
    .cpu_hold    (cpu_hold),
    .load_done   (load_done),
    .load_error  (load_error),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  wr_t         exp_q[$];     // writes the model still expects
  int          wr_cyc[$];    // cycle stamp of each observed write
  logic [31:0] tx_words[$];  // program for the next load

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Every write pulse must match the next entry the model expects.
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      wr_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'd1, 32'd0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", bus.mem_addr, e.addr);
        check("wr_data", bus.mem_wdata, e.data);
      end
    end
  end

  // Inputs change 1 time unit after a rising edge, away from the sampling edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Offer one byte with optional idle cycles before it. Stop waiting after a bounded time.
  task automatic send_byte(input logic [7:0] b, input int gap_pct);
    while (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
      bus.in_valid = 1'b0;
      step();
    end
    // NOTE: bench stimulus is driven with blocking assignments from the
    // procedural thread; the DUT samples it at the following edge.
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    for (int t = 0; t < 100; t++) begin
      if (bus.in_ready === 1'b1) begin
        step();
        bus.in_valid = 1'b0;
        return;
      end
      step();
    end
    bus.in_valid = 1'b0;
    check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap_pct, input int idx);
    for (int k = 3; k >= 0; k--) send_byte(w[8*k +: 8], gap_pct);
    check("we_after_word", 32'(bus.mem_we), 32'd1);
    check("wl_at_write", 32'(words_loaded), 32'(idx + 1));
  endtask

  // Send the header and the words in tx_words, then check the final status.
  task automatic run_load(input logic [31:0] n, input int gap_pct, input logic [31:0] exp_wl);
    for (int i = 0; i < int'(n); i++) begin
      wr_t e;
      e.addr = BASE_ADDR + 32'(4 * i);
      e.data = tx_words[i];
      exp_q.push_back(e);
    end
    for (int k = 3; k >= 0; k--) send_byte(n[8*k +: 8], gap_pct);
    if (n == 32'd0) begin
      check("n0_done", 32'(load_done), 32'd1);
      check("n0_hold", 32'(cpu_hold), 32'd0);
      check("n0_wl", 32'(words_loaded), 32'd0);
      check("n0_no_we", 32'(bus.mem_we), 32'd0);
      return;
    end
    for (int i = 0; i < int'(n); i++) send_word(tx_words[i], gap_pct, i);
    step();
    check("done", 32'(load_done), 32'd1);
    check("hold_low", 32'(cpu_hold), 32'd0);
    check("ready_low", 32'(bus.in_ready), 32'd0);
    check("wl_final", 32'(words_loaded), exp_wl);
    check("writes_left", 32'(exp_q.size()), 32'd0);
  endtask

  vec_t vecs[6];

  initial begin
    vecs = '{
      '{32'd3,           0,  32'd3},
      '{32'd7,           30, 32'd7},
      '{32'd1,           50, 32'd1},
      '{32'd0,           20, 32'd0},
      '{32'(MAX_WORDS),  0,  32'(MAX_WORDS)},
      '{32'd16,          20, 32'd16}
    };
    rst          = 1'b0;
    start        = 1'b0;
    bus.in_data  = 8'h00;
    bus.in_valid = 1'b0;
    do_reset();

    // Reset state
    check("rst_ready", 32'(bus.in_ready), 32'd0);
    check("rst_we", 32'(bus.mem_we), 32'd0);
    check("rst_addr", bus.mem_addr, BASE_ADDR);
    check("rst_wdata", bus.mem_wdata, 32'd0);
    check("rst_hold", 32'(cpu_hold), 32'd1);
    check("rst_done", 32'(load_done), 32'd0);
    check("rst_err", 32'(load_error), 32'd0);
    check("rst_wl", 32'(words_loaded), 32'd0);

    // Reference program, in_valid held high, writes 4 cycles apart
    pulse_start();
    check("hdr_ready", 32'(bus.in_ready), 32'd1);
    tx_words = '{32'h2408_0005, 32'h0109_5020};
    wr_cyc.delete();
    run_load(32'd2, 0, 32'd2);
    if (wr_cyc.size() == 2) check("wr_spacing", 32'(wr_cyc[1] - wr_cyc[0]), 32'd4);
    else check("wr_count", 32'(wr_cyc.size()), 32'd2);
    check("hold_addr", bus.mem_addr, 32'h0000_0004);
    check("hold_wdata", bus.mem_wdata, 32'h0109_5020);

    // Random loads from the table, back to back from DONE
    foreach (vecs[v]) begin
      tx_words.delete();
      for (int i = 0; i < int'(vecs[v].n); i++) tx_words.push_back($urandom);
      pulse_start();
      check("restart_hold", 32'(cpu_hold), 32'd1);
      check("restart_done", 32'(load_done), 32'd0);
      run_load(vecs[v].n, vecs[v].gap_pct, vecs[v].exp_wl);
    end

    // N=1 with in_valid toggling 1-0-0-1-1-0-1 across the data bytes
    begin
      logic [31:0] w;
      logic [6:0]  pat;
      int          idx;
      wr_t         e;
      w   = 32'hA5C3_0F81;
      pat = 7'b1011001;  // read LSB first: 1,0,0,1,1,0,1
      idx = 0;
      e.addr = BASE_ADDR;
      e.data = w;
      exp_q.push_back(e);
      pulse_start();
      for (int k = 3; k >= 0; k--) send_byte(8'(32'd1 >> (8*k)), 0);
      for (int p = 0; p < 7; p++) begin
        bus.in_valid = pat[p];
        bus.in_data  = pat[p] ? w[8*(3-idx) +: 8] : 8'hEE;
        step();
        if (pat[p]) idx++;
      end
      bus.in_valid = 1'b0;
      check("tog_we", 32'(bus.mem_we), 32'd1);
      step();
      check("tog_we_once", 32'(bus.mem_we), 32'd0);
      check("tog_done", 32'(load_done), 32'd1);
      check("tog_wl", 32'(words_loaded), 32'd1);
    end

    // Reset midway through word 3 of a 5-word load
    tx_words = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003};
    pulse_start();
    for (int k = 3; k >= 0; k--) send_byte(8'(32'd5 >> (8*k)), 0);
    for (int i = 0; i < 2; i++) begin
      wr_t e;
      e.addr = BASE_ADDR + 32'(4 * i);
      e.data = tx_words[i];
      exp_q.push_back(e);
      send_word(tx_words[i], 0, i);
    end
    send_byte(8'h33, 0);
    send_byte(8'h33, 0);
    do_reset();
    check("mid_hold", 32'(cpu_hold), 32'd1);
    check("mid_we", 32'(bus.mem_we), 32'd0);
    check("mid_wl", 32'(words_loaded), 32'd0);
    check("mid_ready", 32'(bus.in_ready), 32'd0);
    check("mid_addr", bus.mem_addr, BASE_ADDR);
    tx_words = '{32'hCAFE_0000, 32'hCAFE_0004, 32'hCAFE_0008};
    pulse_start();
    run_load(32'd3, 10, 32'd3);

    // Back-to-back load from DONE
    tx_words = '{32'hDEAD_BEEF};
    pulse_start();
    check("b2b_hold", 32'(cpu_hold), 32'd1);
    check("b2b_done", 32'(load_done), 32'd0);
    run_load(32'd1, 0, 32'd1);

    // Oversized header: sticky error, cleared only by rst
    pulse_start();
    for (int k = 3; k >= 0; k--) send_byte(8'(32'(MAX_WORDS + 1) >> (8*k)), 0);
    check("err_flag", 32'(load_error), 32'd1);
    check("err_ready", 32'(bus.in_ready), 32'd0);
    check("err_hold", 32'(cpu_hold), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h5A;
    step();
    step();
    check("err_no_consume", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b0;
    pulse_start();
    step();
    check("err_start_ignored", 32'(load_error), 32'd1);
    check("err_still_hold", 32'(cpu_hold), 32'd1);
    check("err_not_done", 32'(load_done), 32'd0);
    do_reset();
    check("err_cleared", 32'(load_error), 32'd0);
    check("err_rst_hold", 32'(cpu_hold), 32'd1);

    step();
    check("final_writes_left", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
